// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I(+M) decode with ID/EX handshake,
// load-use bubble insertion, illegal-encoding flag and bubble counter.
// Ports: clk_i/rst_i; IF side if_valid_i, instr_i, pc_i, id_ready_o;
// flush_i; EX side ex_ready_i, ex_valid_o, ex_* fields; bubble_cnt_o.
module decode_ctrl_stage #(
   parameter int XLEN      = 32,
   parameter bit EN_MEXT   = 1'b1,
   parameter int BUBBLE_CW = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 if_valid_i,
   output logic                 id_ready_o,
   input  logic [31:0]          instr_i,
   input  logic [XLEN-1:0]      pc_i,
   input  logic                 flush_i,
   input  logic                 ex_ready_i,
   output logic                 ex_valid_o,
   output logic [XLEN-1:0]      ex_pc_o,
   output logic [XLEN-1:0]      ex_imm_o,
   output logic [4:0]           ex_rs1_o,
   output logic [4:0]           ex_rs2_o,
   output logic [4:0]           ex_rd_o,
   output logic                 ex_RegWrite_o,
   output logic                 ex_MemRead_o,
   output logic                 ex_MemWrite_o,
   output logic                 ex_MemToReg_o,
   output logic                 ex_ALUSrc_o,
   output logic                 ex_Branch_o,
   output logic                 ex_Jump_o,
   output logic                 ex_Jalr_o,
   output logic                 ex_PcSrcA_o,
   output logic [3:0]           ex_ALUOp_o,
   output logic [2:0]           ex_BranchType_o,
   output logic                 ex_MulDiv_o,
   output logic [2:0]           ex_MulDivOp_o,
   output logic                 ex_Illegal_o,
   output logic [BUBBLE_CW-1:0] bubble_cnt_o
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            alu_src;
      logic            branch;
      logic            jump;
      logic            jalr;
      logic            pc_src_a;
      logic [3:0]      alu_op;
      logic [2:0]      br_type;
      logic            muldiv;
      logic [2:0]      md_op;
      logic            illegal;
   } ctl_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      ctl_t            ctl;
   } ent_t;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm32;
   logic        ill;
   logic        use1;
   logic        use2;
   ctl_t        ctl;
   ent_t        dec;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   always_comb begin
      ctl   = '0;
      imm32 = '0;
      ill   = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
      unique case (opc)
         7'b0110111: begin
            imm32         = {instr_i[31:12], 12'b0};
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.alu_op    = ALU_LUI;
         end
         7'b0010111: begin
            imm32         = {instr_i[31:12], 12'b0};
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.pc_src_a  = 1'b1;
         end
         7'b1101111: begin
            imm32 = {{12{instr_i[31]}}, instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
            ctl.reg_write = 1'b1;
            ctl.jump      = 1'b1;
         end
         7'b1100111: begin
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            ctl.reg_write = 1'b1;
            ctl.jalr      = 1'b1;
            ctl.alu_src   = 1'b1;
            use1          = 1'b1;
            ill           = (f3 != 3'b000);
         end
         7'b1100011: begin
            imm32 = {{20{instr_i[31]}}, instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
            ctl.branch  = 1'b1;
            ctl.br_type = f3;
            ctl.alu_op  = ALU_SUB;
            use1        = 1'b1;
            use2        = 1'b1;
            ill         = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b0000011: begin
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            ctl.reg_write  = 1'b1;
            ctl.mem_read   = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.alu_src    = 1'b1;
            use1           = 1'b1;
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin
            imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ctl.mem_write = 1'b1;
            ctl.alu_src   = 1'b1;
            use1          = 1'b1;
            use2          = 1'b1;
            ill           = (f3[2] || f3 == 3'b011);
         end
         7'b0010011: begin
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            use1          = 1'b1;
            unique case (f3)
               3'b000: ctl.alu_op = ALU_ADD;
               3'b010: ctl.alu_op = ALU_SLT;
               3'b011: ctl.alu_op = ALU_SLTU;
               3'b100: ctl.alu_op = ALU_XOR;
               3'b110: ctl.alu_op = ALU_OR;
               3'b111: ctl.alu_op = ALU_AND;
               3'b001: begin
                  ctl.alu_op = ALU_SLL;
                  ill        = (f7 != 7'h00);
               end
               default: begin
                  ctl.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                  ill        = (f7 != 7'h00) && (f7 != 7'h20);
               end
            endcase
         end
         7'b0110011: begin
            ctl.reg_write = 1'b1;
            use1          = 1'b1;
            use2          = 1'b1;
            if (f7 == 7'h00) begin
               unique case (f3)
                  3'b000:  ctl.alu_op = ALU_ADD;
                  3'b001:  ctl.alu_op = ALU_SLL;
                  3'b010:  ctl.alu_op = ALU_SLT;
                  3'b011:  ctl.alu_op = ALU_SLTU;
                  3'b100:  ctl.alu_op = ALU_XOR;
                  3'b101:  ctl.alu_op = ALU_SRL;
                  3'b110:  ctl.alu_op = ALU_OR;
                  default: ctl.alu_op = ALU_AND;
               endcase
            end else if (f7 == 7'h20) begin
               ctl.alu_op = (f3 == 3'b101) ? ALU_SRA : ALU_SUB;
               ill        = (f3 != 3'b000) && (f3 != 3'b101);
            end else if (f7 == 7'h01 && EN_MEXT) begin
               ctl.muldiv = 1'b1;
               ctl.md_op  = f3;
            end else begin
               ill = 1'b1;
            end
         end
         // FENCE is a no-op in this in-order pipe
         7'b0001111: ;
         default: ill = 1'b1;
      endcase
      if (instr_i[1:0] != 2'b11) ill = 1'b1;
      ctl.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
      if (ill) begin
         ctl         = '0;
         ctl.illegal = 1'b1;
         use1        = 1'b0;
         use2        = 1'b0;
      end
   end

   assign dec = '{pc: pc_i, rs1: instr_i[19:15], rs2: instr_i[24:20],
                  rd: instr_i[11:7], ctl: ctl};

   ent_t                 ent_q, ent_d;
   logic                 valid_q, valid_d;
   logic [BUBBLE_CW-1:0] cnt_q, cnt_d;
   logic                 hazard;
   logic                 adv;
   logic                 xfer;

   assign hazard = valid_q && ent_q.ctl.mem_read && (ent_q.rd != 5'd0) &&
                   ((use1 && ent_q.rd == dec.rs1) ||
                    (use2 && ent_q.rd == dec.rs2));
   assign adv        = !valid_q || ex_ready_i;
   assign id_ready_o = adv && !hazard && !flush_i && !rst_i;
   assign xfer       = if_valid_i && id_ready_o;

   always_comb begin
      valid_d = valid_q;
      ent_d   = ent_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (adv && hazard && if_valid_i) begin
         valid_d = 1'b0;
         if (cnt_q != '1) cnt_d = cnt_q + BUBBLE_CW'(1);
      end else if (xfer) begin
         valid_d = 1'b1;
         ent_d   = dec;
      end else if (adv) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ent_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ent_q   <= ent_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid_o      = valid_q;
   assign ex_pc_o         = ent_q.pc;
   assign ex_imm_o        = ent_q.ctl.imm;
   assign ex_rs1_o        = ent_q.rs1;
   assign ex_rs2_o        = ent_q.rs2;
   assign ex_rd_o         = ent_q.rd;
   assign ex_RegWrite_o   = ent_q.ctl.reg_write;
   assign ex_MemRead_o    = ent_q.ctl.mem_read;
   assign ex_MemWrite_o   = ent_q.ctl.mem_write;
   assign ex_MemToReg_o   = ent_q.ctl.mem_to_reg;
   assign ex_ALUSrc_o     = ent_q.ctl.alu_src;
   assign ex_Branch_o     = ent_q.ctl.branch;
   assign ex_Jump_o       = ent_q.ctl.jump;
   assign ex_Jalr_o       = ent_q.ctl.jalr;
   assign ex_PcSrcA_o     = ent_q.ctl.pc_src_a;
   assign ex_ALUOp_o      = ent_q.ctl.alu_op;
   assign ex_BranchType_o = ent_q.ctl.br_type;
   assign ex_MulDiv_o     = ent_q.ctl.muldiv;
   assign ex_MulDivOp_o   = ent_q.ctl.md_op;
   assign ex_Illegal_o    = ent_q.ctl.illegal;
   assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed vectors for decode_ctrl_stage.
// Main DUT: EN_MEXT=1, BUBBLE_CW=2. Second DUT: EN_MEXT=0.
module tb_decode_ctrl_stage;
   logic        clk = 1'b0;
   logic        rst, if_valid, flush, ex_ready;
   logic [31:0] instr, pc;
   int          n_run = 0;
   int          n_fail = 0;

   localparam logic [31:0] ADDI5  = 32'h00500093;
   localparam logic [31:0] ADDIM1 = 32'hFFF00113;
   localparam logic [31:0] LW5    = 32'h00012283;
   localparam logic [31:0] ADD657 = 32'h00728333;
   localparam logic [31:0] LW0    = 32'h00012003;
   localparam logic [31:0] ADD607 = 32'h00700333;
   localparam logic [31:0] SW8    = 32'h00512423;
   localparam logic [31:0] BEQ8   = 32'h00208463;
   localparam logic [31:0] MUL    = 32'h022081B3;
   localparam logic [31:0] LUI    = 32'h123451B7;
   localparam logic [31:0] SLLIX  = 32'h40101093;
   localparam logic [31:0] BR010  = 32'h00002063;

   always #5 clk = ~clk;

   logic        a_rdy, a_v, a_rw, a_mr, a_mw, a_m2r, a_as, a_br;
   logic        a_j, a_jr, a_pa, a_md, a_il;
   logic [31:0] a_pc, a_imm;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [3:0]  a_op;
   logic [2:0]  a_bt, a_mop;
   logic [1:0]  a_cnt;

   logic        b_rdy, b_v, b_rw, b_mr, b_mw, b_m2r, b_as, b_br;
   logic        b_j, b_jr, b_pa, b_md, b_il;
   logic [31:0] b_pc, b_imm;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [3:0]  b_op;
   logic [2:0]  b_bt, b_mop;
   logic [15:0] b_cnt;

   decode_ctrl_stage #(.XLEN(32), .EN_MEXT(1'b1), .BUBBLE_CW(2)) dut (
      .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid),
      .id_ready_o(a_rdy), .instr_i(instr), .pc_i(pc),
      .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(a_v),
      .ex_pc_o(a_pc), .ex_imm_o(a_imm), .ex_rs1_o(a_rs1),
      .ex_rs2_o(a_rs2), .ex_rd_o(a_rd), .ex_RegWrite_o(a_rw),
      .ex_MemRead_o(a_mr), .ex_MemWrite_o(a_mw),
      .ex_MemToReg_o(a_m2r), .ex_ALUSrc_o(a_as),
      .ex_Branch_o(a_br), .ex_Jump_o(a_j), .ex_Jalr_o(a_jr),
      .ex_PcSrcA_o(a_pa), .ex_ALUOp_o(a_op),
      .ex_BranchType_o(a_bt), .ex_MulDiv_o(a_md),
      .ex_MulDivOp_o(a_mop), .ex_Illegal_o(a_il),
      .bubble_cnt_o(a_cnt));

   decode_ctrl_stage #(.XLEN(32), .EN_MEXT(1'b0), .BUBBLE_CW(16)) dut_nm (
      .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid),
      .id_ready_o(b_rdy), .instr_i(instr), .pc_i(pc),
      .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(b_v),
      .ex_pc_o(b_pc), .ex_imm_o(b_imm), .ex_rs1_o(b_rs1),
      .ex_rs2_o(b_rs2), .ex_rd_o(b_rd), .ex_RegWrite_o(b_rw),
      .ex_MemRead_o(b_mr), .ex_MemWrite_o(b_mw),
      .ex_MemToReg_o(b_m2r), .ex_ALUSrc_o(b_as),
      .ex_Branch_o(b_br), .ex_Jump_o(b_j), .ex_Jalr_o(b_jr),
      .ex_PcSrcA_o(b_pa), .ex_ALUOp_o(b_op),
      .ex_BranchType_o(b_bt), .ex_MulDiv_o(b_md),
      .ex_MulDivOp_o(b_mop), .ex_Illegal_o(b_il),
      .bubble_cnt_o(b_cnt));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use(input logic [31:0] exp_cnt);
      instr = LW5;
      tick();
      instr = ADD657;
      tick();
      check("sat_bubble_valid", {31'd0, a_v}, 32'd0);
      check("sat_cnt", {30'd0, a_cnt}, exp_cnt);
      tick();
      check("sat_add_valid", {31'd0, a_v}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b1; flush = 1'b0;
      ex_ready = 1'b1; instr = ADDI5; pc = 32'h100;
      tick();
      tick();
      check("rst_id_ready", {31'd0, a_rdy}, 32'd0);
      check("rst_ex_valid", {31'd0, a_v}, 32'd0);
      check("rst_cnt", {30'd0, a_cnt}, 32'd0);
      check("rst_imm", a_imm, 32'd0);
      rst = 1'b0;
      #1;
      check("addi_id_ready", {31'd0, a_rdy}, 32'd1);
      tick();
      check("addi_valid", {31'd0, a_v}, 32'd1);
      check("addi_alusrc", {31'd0, a_as}, 32'd1);
      check("addi_aluop", {28'd0, a_op}, 32'd0);
      check("addi_imm", a_imm, 32'd5);
      check("addi_rd", {27'd0, a_rd}, 32'd1);
      check("addi_pc", a_pc, 32'h100);
      check("addi_regwrite", {31'd0, a_rw}, 32'd1);

      instr = LW5; pc = 32'h104;
      tick();
      check("lw_memread", {31'd0, a_mr}, 32'd1);
      check("lw_rd", {27'd0, a_rd}, 32'd5);
      instr = ADD657; pc = 32'h108;
      #1;
      check("lu_id_ready", {31'd0, a_rdy}, 32'd0);
      tick();
      check("lu_bubble", {31'd0, a_v}, 32'd0);
      check("lu_cnt", {30'd0, a_cnt}, 32'd1);
      check("lu_id_ready2", {31'd0, a_rdy}, 32'd1);
      tick();
      check("add_valid", {31'd0, a_v}, 32'd1);
      check("add_rd", {27'd0, a_rd}, 32'd6);
      check("add_rs1", {27'd0, a_rs1}, 32'd5);
      check("add_rs2", {27'd0, a_rs2}, 32'd7);
      check("add_pc", a_pc, 32'h108);

      instr = LW0;
      tick();
      instr = ADD607;
      #1;
      check("x0_id_ready", {31'd0, a_rdy}, 32'd1);
      tick();
      check("x0_valid", {31'd0, a_v}, 32'd1);
      check("x0_rd", {27'd0, a_rd}, 32'd6);
      check("x0_cnt", {30'd0, a_cnt}, 32'd1);

      instr = SW8; pc = 32'h200;
      tick();
      ex_ready = 1'b0; instr = ADDI5; pc = 32'h204;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_id_ready", {31'd0, a_rdy}, 32'd0);
         tick();
         check("stall_valid", {31'd0, a_v}, 32'd1);
         check("stall_memwrite", {31'd0, a_mw}, 32'd1);
         check("stall_imm", a_imm, 32'd8);
         check("stall_pc", a_pc, 32'h200);
      end
      ex_ready = 1'b1;
      #1;
      check("release_id_ready", {31'd0, a_rdy}, 32'd1);
      tick();
      check("release_imm", a_imm, 32'd5);
      check("release_pc", a_pc, 32'h204);

      instr = BEQ8; pc = 32'h300;
      tick();
      check("beq_branch", {31'd0, a_br}, 32'd1);
      check("beq_imm", a_imm, 32'd8);
      check("beq_regwrite", {31'd0, a_rw}, 32'd0);
      ex_ready = 1'b0; flush = 1'b1; instr = ADDI5;
      #1;
      check("flush_id_ready", {31'd0, a_rdy}, 32'd0);
      tick();
      flush = 1'b0; if_valid = 1'b0;
      check("flush_valid", {31'd0, a_v}, 32'd0);
      tick();
      check("flush_noaccept", {31'd0, a_v}, 32'd0);

      ex_ready = 1'b1; if_valid = 1'b1; instr = MUL;
      tick();
      check("mul_muldiv", {31'd0, a_md}, 32'd1);
      check("mul_op", {29'd0, a_mop}, 32'd0);
      check("mul_regwrite", {31'd0, a_rw}, 32'd1);
      check("mul_aluop", {28'd0, a_op}, 32'd0);
      check("mul_illegal", {31'd0, a_il}, 32'd0);
      check("nm_mul_valid", {31'd0, b_v}, 32'd1);
      check("nm_mul_illegal", {31'd0, b_il}, 32'd1);
      check("nm_mul_regwrite", {31'd0, b_rw}, 32'd0);
      check("nm_mul_muldiv", {31'd0, b_md}, 32'd0);
      instr = 32'hFFFFFFFF;
      tick();
      check("ones_valid", {31'd0, a_v}, 32'd1);
      check("ones_illegal", {31'd0, a_il}, 32'd1);
      check("ones_regwrite", {31'd0, a_rw}, 32'd0);
      instr = LUI;
      tick();
      check("lui_imm", a_imm, 32'h12345000);
      check("lui_aluop", {28'd0, a_op}, 32'd10);
      check("lui_illegal", {31'd0, a_il}, 32'd0);
      instr = ADDIM1;
      tick();
      check("addim1_imm", a_imm, 32'hFFFFFFFF);
      instr = SLLIX;
      tick();
      check("slli_bad", {31'd0, a_il}, 32'd1);
      instr = BR010;
      tick();
      check("br010_illegal", {31'd0, a_il}, 32'd1);
      check("br010_branch", {31'd0, a_br}, 32'd0);

      load_use(32'd2);
      load_use(32'd3);
      load_use(32'd3);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
